// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bit positions for the execute stage.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        ORR = 4'd3,
        EOR = 4'd4,
        MOV = 4'd5,
        CMP = 4'd6,
        LSL = 4'd7,
        LSR = 4'd8,
        ASR = 4'd9
    } op_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/exec_unit_alu_core.sv
// Combinational ALU: computes result, NZCV and the write/flag controls for one op.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] res,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             wr_en,
    output logic             flag_force,
    output logic             op_ok
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0]  ext;
    logic [SW-1:0]   sh;

    assign sh = b[SW-1:0];

    always_comb begin
        res        = '0;
        ext        = '0;
        c          = c_in;
        v          = v_in;
        wr_en      = 1'b1;
        flag_force = 1'b0;
        op_ok      = 1'b1;
        case (op)
            ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                res = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            SUB, CMP: begin
                ext        = {1'b0, a} - {1'b0, b};
                res        = ext[WIDTH-1:0];
                c          = ~ext[WIDTH];
                v          = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
                wr_en      = (op == SUB);
                flag_force = (op == CMP);
            end
            AND: res = a & b;
            ORR: res = a | b;
            EOR: res = a ^ b;
            MOV: res = b;
            // Shifts run on a WIDTH+1 vector so the last bit out lands in the spare bit
            LSL: begin
                ext = {1'b0, a} << sh;
                res = ext[WIDTH-1:0];
                if (sh != '0) c = ext[WIDTH];
            end
            LSR: begin
                ext = {a, 1'b0} >> sh;
                res = ext[WIDTH:1];
                if (sh != '0) c = ext[0];
            end
            ASR: begin
                ext = $signed({a, 1'b0}) >>> sh;
                res = ext[WIDTH:1];
                if (sh != '0) c = ext[0];
            end
            default: begin
                wr_en = 1'b0;
                op_ok = 1'b0;
            end
        endcase
        n = res[WIDTH-1];
        z = (res == '0);
    end

endmodule

// File: rtl/exec_unit.sv
// Single-cycle execute stage: register file, ALU and registered NZCV flags/result.
module exec_unit
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [3:0]       opcode,
    input  logic             set_flags,
    input  logic             use_imm,
    input  logic [RW-1:0]    rd,
    input  logic [RW-1:0]    rn,
    input  logic [RW-1:0]    rm,
    input  logic [WIDTH-1:0] imm,
    output logic [3:0]       ALUFlags,
    output logic [WIDTH-1:0] result,
    input  logic [RW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_n;
    logic             alu_z;
    logic             alu_c;
    logic             alu_v;
    logic             alu_wr;
    logic             alu_force;
    logic             alu_ok;

    assign op_a     = regs[rn];
    assign op_b     = use_imm ? imm : regs[rm];
    assign dbg_data = regs[dbg_addr];

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op         (opcode),
        .a          (op_a),
        .b          (op_b),
        .c_in       (ALUFlags[FLAG_C]),
        .v_in       (ALUFlags[FLAG_V]),
        .res        (alu_res),
        .n          (alu_n),
        .z          (alu_z),
        .c          (alu_c),
        .v          (alu_v),
        .wr_en      (alu_wr),
        .flag_force (alu_force),
        .op_ok      (alu_ok)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
            result   <= '0;
            ALUFlags <= '0;
        end else if (instr_valid) begin
            if (alu_wr) regs[rd] <= alu_res;
            if (alu_ok) result <= alu_res;
            if (alu_ok && (set_flags || alu_force))
                ALUFlags <= {alu_n, alu_v, alu_c, alu_z};
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: expectations queued per step, checked after the edge.
module tb_exec_unit;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       instr_valid = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       set_flags = 1'b0;
    logic       use_imm = 1'b0;
    logic [2:0] rd = 3'd0;
    logic [2:0] rn = 3'd0;
    logic [2:0] rm = 3'd0;
    logic [7:0] imm = 8'd0;
    logic [3:0] ALUFlags;
    logic [7:0] result;
    logic [2:0] dbg_addr = 3'd0;
    logic [7:0] dbg_data;

    typedef struct {
        string      tag;
        int         kind;   // 0 result, 1 flags, 2 register
        int         idx;
        logic [7:0] exp;
    } chk_t;

    chk_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    exec_unit #(.WIDTH(8), .NREGS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .set_flags   (set_flags),
        .use_imm     (use_imm),
        .rd          (rd),
        .rn          (rn),
        .rm          (rm),
        .imm         (imm),
        .ALUFlags    (ALUFlags),
        .result      (result),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input int kind, input int idx, input logic [7:0] exp);
        chk_t c;
        c.tag  = tag;
        c.kind = kind;
        c.idx  = idx;
        c.exp  = exp;
        sbq.push_back(c);
    endtask

    task automatic drain();
        chk_t       c;
        logic [7:0] obs;
        while (sbq.size() > 0) begin
            c = sbq.pop_front();
            if (c.kind == 0) begin
                obs = result;
            end else if (c.kind == 1) begin
                obs = {4'b0000, ALUFlags};
            end else begin
                dbg_addr = c.idx[2:0];
                #1;
                obs = dbg_data;
            end
            total++;
            assert (obs === c.exp) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", c.tag, obs, c.exp);
            end
        end
    endtask

    // One instruction: drive at negedge, execute on posedge, then deassert valid
    task automatic step(input logic v, input logic [3:0] op, input logic s, input logic ui,
                        input logic [2:0] d, input logic [2:0] n_, input logic [2:0] m,
                        input logic [7:0] im);
        @(negedge clk);
        instr_valid = v;
        opcode      = op;
        set_flags   = s;
        use_imm     = ui;
        rd          = d;
        rn          = n_;
        rm          = m;
        imm         = im;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    initial begin
        #12;
        push("rst_result", 0, 0, 8'h00);
        push("rst_flags", 1, 0, 8'h00);
        push("rst_r0", 2, 0, 8'h00);
        drain();
        @(negedge clk);
        reset = 1'b1;

        // write a couple of registers, then reset asynchronously mid-run
        step(1, MOV, 0, 1, 3'd1, 3'd0, 3'd0, 8'hAA);
        push("mov_r1_aa", 2, 1, 8'hAA);
        push("mov_res_aa", 0, 0, 8'hAA);
        drain();
        step(1, ADD, 1, 1, 3'd2, 3'd1, 3'd0, 8'h56);
        push("add_wrap_r2", 2, 2, 8'h00);
        push("add_wrap_flags", 1, 0, 8'h03);
        drain();
        #1 reset = 1'b0;
        #1;
        push("midrst_r1", 2, 1, 8'h00);
        push("midrst_r2", 2, 2, 8'h00);
        push("midrst_result", 0, 0, 8'h00);
        push("midrst_flags", 1, 0, 8'h00);
        drain();
        @(negedge clk);
        reset = 1'b1;

        // signed overflow into the sign bit
        step(1, MOV, 0, 1, 3'd1, 3'd0, 3'd0, 8'h7F);
        push("mov_flags_hold", 1, 0, 8'h00);
        drain();
        step(1, ADD, 1, 1, 3'd2, 3'd1, 3'd0, 8'h01);
        push("add_ovf_r2", 2, 2, 8'h80);
        push("add_ovf_flags", 1, 0, 8'h0C);
        drain();

        // CMP updates flags regardless of set_flags and never writes
        step(1, MOV, 0, 1, 3'd3, 3'd0, 3'd0, 8'h05);
        step(1, CMP, 0, 1, 3'd3, 3'd3, 3'd0, 8'h05);
        push("cmp_eq_flags", 1, 0, 8'h03);
        push("cmp_eq_result", 0, 0, 8'h00);
        push("cmp_eq_r3", 2, 3, 8'h05);
        drain();
        step(1, CMP, 0, 1, 3'd3, 3'd3, 3'd0, 8'h06);
        push("cmp_lt_flags", 1, 0, 8'h08);
        push("cmp_lt_result", 0, 0, 8'hFF);
        push("cmp_lt_r3", 2, 3, 8'h05);
        drain();

        // shifts: carry is the last bit out, held for a zero shift
        step(1, MOV, 0, 1, 3'd4, 3'd0, 3'd0, 8'h81);
        step(1, LSR, 1, 1, 3'd4, 3'd4, 3'd0, 8'h01);
        push("lsr_r4", 2, 4, 8'h40);
        push("lsr_flags", 1, 0, 8'h02);
        drain();
        step(1, LSL, 1, 1, 3'd4, 3'd4, 3'd0, 8'h00);
        push("lsl0_r4", 2, 4, 8'h40);
        push("lsl0_flags", 1, 0, 8'h02);
        drain();
        step(1, MOV, 0, 1, 3'd5, 3'd0, 3'd0, 8'h90);
        step(1, ASR, 1, 1, 3'd5, 3'd5, 3'd0, 8'h03);
        push("asr_r5", 2, 5, 8'hF2);
        push("asr_flags", 1, 0, 8'h08);
        drain();
        step(1, LSL, 1, 1, 3'd5, 3'd5, 3'd0, 8'h01);
        push("lsl1_r5", 2, 5, 8'hE4);
        push("lsl1_flags", 1, 0, 8'h0A);
        drain();

        // logic op without set_flags, undefined opcode, idle cycle
        step(1, AND, 0, 1, 3'd5, 3'd4, 3'd0, 8'h00);
        push("and_r5", 2, 5, 8'h00);
        push("and_flags_hold", 1, 0, 8'h0A);
        push("and_result", 0, 0, 8'h00);
        drain();
        step(1, 4'd15, 1, 1, 3'd5, 3'd4, 3'd0, 8'hFF);
        push("nop_r5", 2, 5, 8'h00);
        push("nop_flags", 1, 0, 8'h0A);
        push("nop_result", 0, 0, 8'h00);
        drain();
        step(0, MOV, 1, 1, 3'd5, 3'd0, 3'd0, 8'h33);
        push("idle_r5", 2, 5, 8'h00);
        push("idle_flags", 1, 0, 8'h0A);
        drain();

        // decrement loop with an idle cycle in the middle
        step(1, MOV, 0, 1, 3'd6, 3'd0, 3'd0, 8'h03);
        step(1, SUB, 1, 1, 3'd6, 3'd6, 3'd0, 8'h01);
        push("dec1_r6", 2, 6, 8'h02);
        push("dec1_flags", 1, 0, 8'h02);
        drain();
        step(0, SUB, 1, 1, 3'd6, 3'd6, 3'd0, 8'h01);
        push("dec_idle_r6", 2, 6, 8'h02);
        push("dec_idle_flags", 1, 0, 8'h02);
        drain();
        step(1, SUB, 1, 1, 3'd6, 3'd6, 3'd0, 8'h01);
        push("dec2_flags", 1, 0, 8'h02);
        drain();
        step(1, SUB, 1, 1, 3'd6, 3'd6, 3'd0, 8'h01);
        push("dec3_r6", 2, 6, 8'h00);
        push("dec3_flags", 1, 0, 8'h03);
        drain();

        // register operands, rd==rn, and SUB signed overflow
        step(1, ORR, 1, 0, 3'd2, 3'd1, 3'd3, 8'h00);
        push("orr_r2", 2, 2, 8'h7F);
        push("orr_flags", 1, 0, 8'h02);
        drain();
        step(1, EOR, 1, 0, 3'd2, 3'd2, 3'd2, 8'h00);
        push("eor_r2", 2, 2, 8'h00);
        push("eor_flags", 1, 0, 8'h03);
        drain();
        step(1, MOV, 0, 1, 3'd7, 3'd0, 3'd0, 8'h80);
        step(1, SUB, 1, 1, 3'd7, 3'd7, 3'd0, 8'h01);
        push("sub_ovf_r7", 2, 7, 8'h7F);
        push("sub_ovf_flags", 1, 0, 8'h06);
        push("sub_ovf_result", 0, 0, 8'h7F);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
